cpu_sequencer: RTL and testbench

Multi-cycle fetch/decode/execute controller for the eight-bit computer. It fetches 8-bit instructions over a req/ack instruction-memory port. It drives the two-register file through that file's write port (`we`/`waddr`/`wdata`) and its combinational read port (`rsel`/`rdata`). It exposes a valid/ready output port and a halt flag, and is the sole writer and reader of the register file.

---
 rtl/cpu_pkg.sv | 25 ++
 rtl/alu8.sv | 26 ++
 rtl/cpu_sequencer.sv | 154 +++++++++++++++
 tb/tb_cpu_sequencer.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - opcode and sequencer state encodings shared by the eight-bit computer
package cpu_pkg;

    localparam logic [2:0] OP_LDI = 3'b000;
    localparam logic [2:0] OP_MOV = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;
    localparam logic [2:0] OP_JMP = 3'b100;
    localparam logic [2:0] OP_JZ  = 3'b101;
    localparam logic [2:0] OP_OUT = 3'b110;
    localparam logic [2:0] OP_HLT = 3'b111;

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_RDA      = 4'd3,
        S_RDB      = 4'd4,
        S_WB       = 4'd5,
        S_FETCH_OP = 4'd6,
        S_OUT      = 4'd7,
        S_HALT     = 4'd8
    } state_t;

endpackage

// File: rtl/alu8.sv
// rtl/alu8.sv - combinational 8-bit add/subtract with carry/borrow and zero outputs
module alu8 (
    input  logic [7:0] i_a,
    input  logic [7:0] i_b,
    input  logic       i_sub,
    output logic [7:0] o_result,
    output logic       o_c,
    output logic       o_z
);

    logic [8:0] w_sum;

    // Bit 8 of the 9-bit difference is the borrow, set exactly when a < b.
    always_comb begin
        if (i_sub) begin
            w_sum = {1'b0, i_a} - {1'b0, i_b};
        end else begin
            w_sum = {1'b0, i_a} + {1'b0, i_b};
        end
    end

    assign o_result = w_sum[7:0];
    assign o_c      = w_sum[8];
    assign o_z      = (w_sum[7:0] == 8'h00);

endmodule

// File: rtl/cpu_sequencer.sv
// rtl/cpu_sequencer.sv - multi-cycle fetch/decode/execute controller for the eight-bit computer
module cpu_sequencer
    import cpu_pkg::*;
#(
    parameter logic [7:0] RESET_PC = 8'h00
) (
    input  logic       clk,
    input  logic       reset,
    output logic       o_imem_req,
    output logic [7:0] o_imem_addr,
    input  logic       i_imem_ack,
    input  logic [7:0] i_imem_rdata,
    output logic       o_rf_we,
    output logic       o_rf_waddr,
    output logic [7:0] o_rf_wdata,
    output logic       o_rf_rsel,
    input  logic [7:0] i_rf_rdata,
    output logic       o_out_valid,
    input  logic       i_out_ready,
    output logic [7:0] o_out_data,
    output logic       o_halted,
    output logic       o_flag_z,
    output logic       o_flag_c
);

    state_t     r_state;
    state_t     w_next;
    logic [7:0] r_pc;
    logic [7:0] r_ir;
    logic [7:0] r_a;
    logic [7:0] r_b;
    logic       r_z;
    logic       r_c;
    logic [2:0] w_op;
    logic [7:0] w_alu_result;
    logic       w_alu_c;
    logic       w_alu_z;
    logic       w_is_alu;

    assign w_op     = r_ir[7:5];
    assign w_is_alu = (w_op == OP_ADD) || (w_op == OP_SUB);

    alu8 u_alu (
        .i_a      (r_a),
        .i_b      (r_b),
        .i_sub    (r_ir[5]),
        .o_result (w_alu_result),
        .o_c      (w_alu_c),
        .o_z      (w_alu_z)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_pc    <= RESET_PC;
            r_ir    <= 8'h00;
            r_a     <= 8'h00;
            r_b     <= 8'h00;
            r_z     <= 1'b0;
            r_c     <= 1'b0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_FETCH: if (i_imem_ack) begin
                    r_ir <= i_imem_rdata;
                    r_pc <= r_pc + 8'd1;
                end
                S_RDA: r_a <= i_rf_rdata;
                S_RDB: r_b <= i_rf_rdata;
                S_WB: if (w_is_alu) begin
                    r_z <= w_alu_z;
                    r_c <= w_alu_c;
                end
                // A taken jump replaces the operand-fetch increment.
                S_FETCH_OP: if (i_imem_ack) begin
                    if (w_op == OP_JMP || (w_op == OP_JZ && r_z)) begin
                        r_pc <= i_imem_rdata;
                    end else begin
                        r_pc <= r_pc + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_next      = r_state;
        o_imem_req  = 1'b0;
        o_imem_addr = 8'h00;
        o_rf_we     = 1'b0;
        o_rf_waddr  = 1'b0;
        o_rf_wdata  = 8'h00;
        o_rf_rsel   = 1'b0;
        o_out_valid = 1'b0;
        o_out_data  = 8'h00;
        o_halted    = 1'b0;
        case (r_state)
            S_IDLE: w_next = S_FETCH;
            S_FETCH: begin
                o_imem_req  = 1'b1;
                o_imem_addr = r_pc;
                if (i_imem_ack) w_next = S_DECODE;
            end
            S_DECODE: begin
                case (w_op)
                    OP_LDI:                         w_next = S_WB;
                    OP_MOV, OP_ADD, OP_SUB, OP_OUT: w_next = S_RDA;
                    OP_JMP, OP_JZ:                  w_next = S_FETCH_OP;
                    default:                        w_next = S_HALT;
                endcase
            end
            S_RDA: begin
                case (w_op)
                    OP_MOV: begin o_rf_rsel = r_ir[3]; w_next = S_WB;  end
                    OP_OUT: begin o_rf_rsel = r_ir[4]; w_next = S_OUT; end
                    OP_ADD, OP_SUB: w_next = S_RDB;
                    default:        w_next = S_FETCH;
                endcase
            end
            S_RDB: begin
                o_rf_rsel = 1'b1;
                w_next    = S_WB;
            end
            S_WB: begin
                o_rf_we    = 1'b1;
                o_rf_waddr = r_ir[4];
                case (w_op)
                    OP_LDI:         o_rf_wdata = {4'b0000, r_ir[3:0]};
                    OP_MOV:         o_rf_wdata = r_a;
                    OP_ADD, OP_SUB: o_rf_wdata = w_alu_result;
                    default:        o_rf_wdata = 8'h00;
                endcase
                w_next = S_FETCH;
            end
            S_FETCH_OP: begin
                o_imem_req  = 1'b1;
                o_imem_addr = r_pc;
                if (i_imem_ack) w_next = S_FETCH;
            end
            S_OUT: begin
                o_out_valid = 1'b1;
                o_out_data  = r_a;
                if (i_out_ready) w_next = S_FETCH;
            end
            S_HALT: o_halted = 1'b1;
            default: w_next = S_IDLE;
        endcase
    end

    assign o_flag_z = r_z;
    assign o_flag_c = r_c;

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb/tb_cpu_sequencer.sv - scoreboard bench running small programs through cpu_sequencer
module tb_cpu_sequencer;
    import cpu_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       o_imem_req;
    logic [7:0] o_imem_addr;
    logic       i_imem_ack = 1'b0;
    logic [7:0] i_imem_rdata = 8'h00;
    logic       o_rf_we;
    logic       o_rf_waddr;
    logic [7:0] o_rf_wdata;
    logic       o_rf_rsel;
    logic [7:0] i_rf_rdata;
    logic       o_out_valid;
    logic       i_out_ready = 1'b0;
    logic [7:0] o_out_data;
    logic       o_halted;
    logic       o_flag_z;
    logic       o_flag_c;
    logic [31:0] w_outs;

    logic [7:0] mem [256];
    logic [7:0] rf [2];
    logic [7:0] exp_q [$];
    logic [7:0] fetch_log [$];
    int checks = 0;
    int errors = 0;
    int we_cnt = 0;
    int we_base = 0;
    int fetch_base = 0;
    int ack_delay = 0;
    int ready_delay = 0;
    int wcnt = 0;
    int rcnt = 0;
    logic [7:0] req_addr = 8'h00;
    logic [7:0] out_hold = 8'h00;

    always #5 clk = ~clk;

    cpu_sequencer #(.RESET_PC(8'h00)) dut (
        .clk          (clk),
        .reset        (reset),
        .o_imem_req   (o_imem_req),
        .o_imem_addr  (o_imem_addr),
        .i_imem_ack   (i_imem_ack),
        .i_imem_rdata (i_imem_rdata),
        .o_rf_we      (o_rf_we),
        .o_rf_waddr   (o_rf_waddr),
        .o_rf_wdata   (o_rf_wdata),
        .o_rf_rsel    (o_rf_rsel),
        .i_rf_rdata   (i_rf_rdata),
        .o_out_valid  (o_out_valid),
        .i_out_ready  (i_out_ready),
        .o_out_data   (o_out_data),
        .o_halted     (o_halted),
        .o_flag_z     (o_flag_z),
        .o_flag_c     (o_flag_c)
    );

    assign w_outs = {o_imem_req, o_imem_addr, o_rf_we, o_rf_waddr, o_rf_wdata, o_rf_rsel,
                     o_out_valid, o_out_data, o_halted, o_flag_z, o_flag_c};
    assign i_rf_rdata = rf[o_rf_rsel];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) begin
        if (o_rf_we) begin
            rf[o_rf_waddr] <= o_rf_wdata;
            we_cnt++;
        end
    end

    // Instruction memory: ack after ack_delay wait cycles, rdata valid with ack.
    always @(negedge clk) begin
        if (i_imem_ack) begin
            i_imem_ack = 1'b0;
            wcnt = 0;
        end
        if (reset) begin
            wcnt = 0;
        end else if (o_imem_req) begin
            if (wcnt == 0) req_addr = o_imem_addr;
            else check("imem_addr_stable", 32'(o_imem_addr), 32'(req_addr));
            if (wcnt >= ack_delay) begin
                i_imem_ack   = 1'b1;
                i_imem_rdata = mem[o_imem_addr];
                fetch_log.push_back(o_imem_addr);
            end else begin
                wcnt++;
            end
        end else begin
            check("imem_addr_idle", 32'(o_imem_addr), 32'h0);
            wcnt = 0;
        end
        check("we_exclusive", 32'(o_rf_we & (o_imem_req | o_out_valid)), 32'h0);
    end

    // Output sink: ready after ready_delay wait cycles; scoreboard pops on transfer.
    always @(negedge clk) begin
        if (i_out_ready) begin
            i_out_ready = 1'b0;
            rcnt = 0;
        end
        if (reset) begin
            rcnt = 0;
        end else if (o_out_valid) begin
            if (rcnt == 0) out_hold = o_out_data;
            else check("out_data_stable", 32'(o_out_data), 32'(out_hold));
            if (rcnt >= ready_delay) begin
                i_out_ready = 1'b1;
                if (exp_q.size() == 0) check("out_unexpected", 32'(o_out_data), 32'hFFFF_FFFF);
                else check("out_data", 32'(o_out_data), 32'(exp_q.pop_front()));
            end else begin
                rcnt++;
            end
        end
    end

    function automatic logic [7:0] ldi(input logic r, input logic [3:0] imm);
        return {OP_LDI, r, imm};
    endfunction

    function automatic logic [7:0] op_r(input logic [2:0] op, input logic r);
        return {op, r, 4'b0000};
    endfunction

    function automatic logic [7:0] mov(input logic d, input logic s);
        return {OP_MOV, d, s, 3'b000};
    endfunction

    task automatic put(input int addr, input logic [7:0] v);
        mem[addr] = v;
    endtask

    task automatic clear_prog();
        for (int i = 0; i < 256; i++) mem[i] = {OP_HLT, 5'b00000};
        exp_q.delete();
    endtask

    task automatic load_prog1();
        put(0, ldi(1'b0, 4'd5));
        put(1, ldi(1'b1, 4'd3));
        put(2, op_r(OP_ADD, 1'b0));
        put(3, op_r(OP_OUT, 1'b0));
        put(4, mov(1'b1, 1'b0));
        put(5, op_r(OP_OUT, 1'b1));
        exp_q.push_back(8'h08);
        exp_q.push_back(8'h08);
    endtask

    task automatic start(input int adly, input int rdly);
        ack_delay   = adly;
        ready_delay = rdly;
        we_base     = we_cnt;
        fetch_base  = fetch_log.size();
        @(negedge clk);
        reset = 1'b0;
        #1 check("idle_no_req", 32'(o_imem_req), 32'h0);
        @(negedge clk);
        #1 check("restart_req", 32'(o_imem_req), 32'h1);
        check("restart_addr", 32'(o_imem_addr), 32'h00);
    endtask

    task automatic run_to_halt(input int exp_cycles);
        int n;
        n = 0;
        while (!o_halted && n < 3000) begin
            @(negedge clk);
            n++;
        end
        #1 check("halt_reached", 32'(o_halted), 32'h1);
        if (exp_cycles >= 0) check("cycles_to_halt", 32'(n), 32'(exp_cycles));
        check("out_pending", 32'(exp_q.size()), 32'h0);
    endtask

    task automatic hit_reset();
        int snap;
        #2 reset = 1'b1;
        #1 check("reset_outputs_zero", w_outs, 32'h0);
        snap = we_cnt;
        repeat (3) @(posedge clk);
        #1 check("reset_no_write", 32'(we_cnt), 32'(snap));
        check("reset_outputs_hold", w_outs, 32'h0);
    endtask

    initial begin
        int n;
        clear_prog();
        repeat (2) @(negedge clk);
        #1 check("reset_state", w_outs, 32'h0);

        // LDI/ADD/OUT/MOV/OUT/HLT, zero-wait handshakes.
        load_prog1();
        start(0, 0);
        run_to_halt(25);
        check("p1_flag_z", 32'(o_flag_z), 32'h0);
        check("p1_flag_c", 32'(o_flag_c), 32'h0);
        check("p1_r0", 32'(rf[0]), 32'h08);
        check("p1_r1", 32'(rf[1]), 32'h08);
        check("p1_we_pulses", 32'(we_cnt - we_base), 32'd4);
        hit_reset();

        // SUB with borrow: 2 - 3.
        clear_prog();
        put(0, ldi(1'b0, 4'd2));
        put(1, ldi(1'b1, 4'd3));
        put(2, op_r(OP_SUB, 1'b1));
        put(3, op_r(OP_OUT, 1'b1));
        exp_q.push_back(8'hFF);
        start(0, 0);
        run_to_halt(-1);
        check("sub_borrow_c", 32'(o_flag_c), 32'h1);
        check("sub_borrow_z", 32'(o_flag_z), 32'h0);
        check("sub_borrow_r1", 32'(rf[1]), 32'hFF);
        hit_reset();

        // SUB to zero: 3 - 3, then MOV the result across.
        clear_prog();
        put(0, ldi(1'b0, 4'd3));
        put(1, ldi(1'b1, 4'd3));
        put(2, op_r(OP_SUB, 1'b0));
        put(3, mov(1'b1, 1'b0));
        put(4, op_r(OP_OUT, 1'b1));
        exp_q.push_back(8'h00);
        start(0, 0);
        run_to_halt(-1);
        check("sub_zero_z", 32'(o_flag_z), 32'h1);
        check("sub_zero_c", 32'(o_flag_c), 32'h0);
        check("sub_zero_r0", 32'(rf[0]), 32'h00);
        hit_reset();

        // JZ taken.
        clear_prog();
        put(0, ldi(1'b0, 4'd3));
        put(1, ldi(1'b1, 4'd3));
        put(2, op_r(OP_SUB, 1'b0));
        put(3, {OP_JZ, 5'b00000});
        put(4, 8'h10);
        put(5, op_r(OP_OUT, 1'b1));
        put(8'h10, ldi(1'b0, 4'd7));
        put(8'h11, op_r(OP_OUT, 1'b0));
        exp_q.push_back(8'h07);
        start(0, 0);
        run_to_halt(-1);
        check("jz_taken_addr", 32'(fetch_log[fetch_base + 5]), 32'h10);
        hit_reset();

        // JZ not taken falls through to JZ address + 2.
        clear_prog();
        put(0, ldi(1'b0, 4'd5));
        put(1, ldi(1'b1, 4'd3));
        put(2, op_r(OP_SUB, 1'b0));
        put(3, {OP_JZ, 5'b00000});
        put(4, 8'h10);
        put(5, op_r(OP_OUT, 1'b0));
        put(8'h10, op_r(OP_OUT, 1'b1));
        exp_q.push_back(8'h02);
        start(0, 0);
        run_to_halt(-1);
        check("jz_fall_addr", 32'(fetch_log[fetch_base + 5]), 32'h05);
        hit_reset();

        // JMP at FE with operand 00: operand fetch at FF, next fetch at 0.
        clear_prog();
        put(0, {OP_JZ, 5'b00000});
        put(1, 8'h10);
        put(2, ldi(1'b0, 4'd3));
        put(3, ldi(1'b1, 4'd3));
        put(4, op_r(OP_SUB, 1'b0));
        put(5, {OP_JMP, 5'b00000});
        put(6, 8'hFE);
        put(8'hFE, {OP_JMP, 5'b00000});
        put(8'hFF, 8'h00);
        put(8'h10, op_r(OP_OUT, 1'b0));
        exp_q.push_back(8'h00);
        start(0, 0);
        run_to_halt(-1);
        check("jz_reset_z_fall", 32'(fetch_log[fetch_base + 2]), 32'h02);
        check("jmp_operand_ff", 32'(fetch_log[fetch_base + 8]), 32'hFF);
        check("jmp_wrap_zero", 32'(fetch_log[fetch_base + 9]), 32'h00);
        check("jz_after_wrap", 32'(fetch_log[fetch_base + 11]), 32'h10);
        hit_reset();

        // Ack delayed 3 cycles and ready held low 4 cycles.
        clear_prog();
        load_prog1();
        start(3, 4);
        run_to_halt(54);
        check("slow_r0", 32'(rf[0]), 32'h08);
        check("slow_we_pulses", 32'(we_cnt - we_base), 32'd4);
        hit_reset();

        // Reset during RDB of ADD.
        clear_prog();
        load_prog1();
        start(0, 0);
        repeat (9) @(negedge clk);
        #1 check("rdb_rsel", 32'(o_rf_rsel), 32'h1);
        hit_reset();
        exp_q.delete();

        // Reset during OUT with ready held low.
        clear_prog();
        load_prog1();
        exp_q.delete();
        start(0, 1000);
        n = 0;
        while (!o_out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        #1 check("out_valid_seen", 32'(o_out_valid), 32'h1);
        repeat (3) @(negedge clk);
        hit_reset();

        // Clean recovery after the mid-operation resets.
        clear_prog();
        load_prog1();
        start(0, 0);
        run_to_halt(25);
        check("recover_r1", 32'(rf[1]), 32'h08);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
